// File: rtl/noc_arb_mux_pkg.sv
// Shared NoC definitions used by the packet-level arbiter/multiplexer.
// Holds the default flit width, the flit record layout and the arbiter FSM states.
package optimsoc_noc_pkg;

  localparam int FLIT_WIDTH_DEF = 32;

  typedef struct packed {
    logic                      last;
    logic [FLIT_WIDTH_DEF-1:0] data;
  } flit_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/noc_arb_mux_arb_rr.sv
// Combinational round-robin arbiter: the current grant holder has lowest priority.
// With no request, or when disabled, the current grant is passed through unchanged.
module arb_rr #(
  parameter int N = 2
) (
  input  logic         i_en,
  input  logic [N-1:0] i_req,
  input  logic [N-1:0] i_gnt,
  output logic [N-1:0] o_nxt_gnt
);

  always_comb begin
    int cur;
    int best;
    int best_d;
    int d;
    cur = 0;
    for (int i = 0; i < N; i++) begin
      if (i_gnt[i]) cur = i;
    end
    best   = cur;
    best_d = N;
    // d is the distance past the current holder; the holder itself ends up at N-1
    for (int i = 0; i < N; i++) begin
      d = (i + N - cur - 1) % N;
      if (i_req[i] && (d < best_d)) begin
        best   = i;
        best_d = d;
      end
    end
    o_nxt_gnt = i_gnt;
    if (i_en && (|i_req)) begin
      for (int i = 0; i < N; i++) begin
        o_nxt_gnt[i] = (i == best);
      end
    end
  end

endmodule

// File: rtl/noc_arb_mux_oslice.sv
// Two-entry output skid buffer, only built when NOC_ARB_MUX_OUTREG_EN is defined.
// Full throughput with one cycle latency; the upstream ready depends only on o_full.
`ifdef NOC_ARB_MUX_OUTREG_EN
module noc_arb_mux_oslice #(
  parameter int FLIT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [FLIT_WIDTH-1:0] i_flit,
  input  logic                  i_last,
  output logic                  o_full,
  output logic [FLIT_WIDTH-1:0] o_flit,
  output logic                  o_last,
  output logic                  o_valid,
  input  logic                  i_ready
);

  logic [FLIT_WIDTH-1:0] r_flit [2];
  logic                  r_last [2];
  logic                  r_wptr;
  logic                  r_rptr;
  logic [1:0]            r_cnt;
  logic                  w_push;
  logic                  w_pop;

  assign o_full  = (r_cnt == 2'd2);
  assign o_valid = (r_cnt != 2'd0);
  assign w_push  = i_valid & ~o_full;
  assign w_pop   = o_valid & i_ready;
  assign o_flit  = r_flit[r_rptr];
  assign o_last  = r_last[r_rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= 2'd0;
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // Payload storage carries no reset; occupancy alone decides validity
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_flit[r_wptr] <= i_flit;
      r_last[r_wptr] <= i_last;
    end
  end

endmodule
`endif

// File: rtl/noc_arb_mux.sv
// Packet-level N:1 flit multiplexer; the grant only moves at packet boundaries.
// Define NOC_ARB_MUX_OUTREG_EN to register the outputs through a 2-entry skid buffer.
module noc_arb_mux
  import optimsoc_noc_pkg::*;
#(
  parameter int FLIT_WIDTH = FLIT_WIDTH_DEF,
  parameter int CHANNELS   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS*FLIT_WIDTH-1:0] in_flit,
  input  logic [CHANNELS-1:0]            in_last,
  input  logic [CHANNELS-1:0]            in_valid,
  output logic [CHANNELS-1:0]            in_ready,
  output logic [FLIT_WIDTH-1:0]          out_flit,
  output logic                           out_last,
  output logic                           out_valid,
  input  logic                           out_ready
);

  // Highest channel holds the grant at reset so that channel 0 wins first
  localparam logic [CHANNELS-1:0] GNT_RST = {1'b1, {(CHANNELS-1){1'b0}}};

  state_e                r_state;
  logic [CHANNELS-1:0]   r_gnt;
  logic [CHANNELS-1:0]   w_nxt_gnt;
  logic [CHANNELS-1:0]   w_sel;
  logic                  w_en;
  logic [FLIT_WIDTH-1:0] w_mux_flit;
  logic                  w_mux_last;
  logic                  w_mux_valid;
  logic                  w_acc;
  logic                  w_xfer_last;

  assign w_en = (r_state == IDLE);

  arb_rr #(
    .N (CHANNELS)
  ) u_arb (
    .i_en      (w_en),
    .i_req     (in_valid),
    .i_gnt     (r_gnt),
    .o_nxt_gnt (w_nxt_gnt)
  );

  assign w_sel = w_en ? w_nxt_gnt : r_gnt;

  always_comb begin
    w_mux_flit = '0;
    w_mux_last = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_sel[i]) begin
        w_mux_flit = in_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
        w_mux_last = in_last[i];
      end
    end
  end

  assign w_mux_valid = (|(w_sel & in_valid)) & ~rst;
  assign in_ready    = rst ? '0 : (w_sel & {CHANNELS{w_acc}});
  assign w_xfer_last = w_mux_valid & w_acc & w_mux_last;

`ifdef NOC_ARB_MUX_OUTREG_EN
  logic w_full;

  noc_arb_mux_oslice #(
    .FLIT_WIDTH (FLIT_WIDTH)
  ) u_oslice (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_mux_valid),
    .i_flit  (w_mux_flit),
    .i_last  (w_mux_last),
    .o_full  (w_full),
    .o_flit  (out_flit),
    .o_last  (out_last),
    .o_valid (out_valid),
    .i_ready (out_ready)
  );

  assign w_acc = ~w_full;
`else
  assign w_acc     = out_ready;
  assign out_flit  = w_mux_flit;
  assign out_last  = w_mux_last;
  assign out_valid = w_mux_valid;
`endif

  // A first flit that does not complete its packet locks the channel, even if stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= GNT_RST;
    end else begin
      case (r_state)
        IDLE: begin
          if (|in_valid) begin
            r_gnt <= w_nxt_gnt;
            if (!w_xfer_last) r_state <= LOCKED;
          end
        end
        LOCKED: begin
          if (w_xfer_last) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
